// File: rtl/adc_spi_reader.sv
// adc_spi_reader: paced ADC convert + 3-wire SPI read front-end.
// Delivers one sample per period on a valid/ready port.
module adc_spi_reader #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 4,
  parameter int CNV_CYCLES    = 3,
  parameter int CONV_WAIT     = 70,
  parameter int SAMPLE_PERIOD = 2000,
  parameter bit SIGNED_OUT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              cnv_adc,
  output logic              sck_adc,
  input  logic              sdi_adc,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int M1   = (CNV_CYCLES > CONV_WAIT) ?
                        CNV_CYCLES : CONV_WAIT;
  localparam int CMAX = (M1 > 2 * CLK_DIV) ?
                        M1 : 2 * CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(DATA_W + 1);
  localparam int PW   = $clog2(SAMPLE_PERIOD + 1);

  typedef enum logic [2:0] {
    IDLE, CNV, WAIT, SHIFT, DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     ctr;
  logic [CW-1:0]     ctr_n;
  logic [BW-1:0]     bit_idx;
  logic [BW-1:0]     bit_n;
  logic [PW-1:0]     pcnt;
  logic [DATA_W-1:0] sr;
  logic              tick;
  logic              shift_en;
  logic              load;
  logic              cnv_n;
  logic              sck_n;
  logic              ovr_n;
  logic              valid_n;

  assign tick = en & (pcnt == '0);

  // Sample-period counter, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!en) begin
      pcnt <= '0;
    end else if (pcnt == PW'(SAMPLE_PERIOD - 1)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // FSM state, in-state cycle counter and bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ctr     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      ctr     <= ctr_n;
      bit_idx <= bit_n;
    end
  end

  // Next-state: frame sequencing driven by the cycle counter.
  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    bit_n   = bit_idx;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_n = CNV;
          ctr_n   = '0;
        end
      end
      CNV: begin
        if (ctr == CW'(CNV_CYCLES - 1)) begin
          state_n = WAIT;
          ctr_n   = '0;
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      WAIT: begin
        if (ctr == CW'(CONV_WAIT - 1)) begin
          state_n = SHIFT;
          ctr_n   = '0;
          bit_n   = '0;
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      SHIFT: begin
        if (ctr == CW'(2 * CLK_DIV - 1)) begin
          ctr_n = '0;
          if (bit_idx == BW'(DATA_W - 1)) begin
            state_n = DONE;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ctr_n   = '0;
      end
      default: begin
        state_n = IDLE;
        ctr_n   = '0;
      end
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    shift_en = (state == SHIFT) &&
               (ctr == CW'(CLK_DIV - 1));
    load     = (state == DONE);
    cnv_n    = (state_n == CNV);
    sck_n    = (state_n == SHIFT) &&
               (ctr_n >= CW'(CLK_DIV));
    ovr_n    = (tick && (state != IDLE)) ||
               (load && sample_valid && !sample_ready);
    valid_n  = sample_valid;
    if (load) begin
      valid_n = 1'b1;
    end else if (sample_ready) begin
      valid_n = 1'b0;
    end
  end

  // Registered outputs, shift register and sample latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnv_adc      <= 1'b0;
      sck_adc      <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
      sr           <= '0;
    end else begin
      cnv_adc      <= cnv_n;
      sck_adc      <= sck_n;
      busy         <= (state_n != IDLE);
      overrun      <= ovr_n;
      sample_valid <= valid_n;
      if (shift_en) begin
        sr <= {sr[DATA_W-2:0], sdi_adc};
      end
      if (load) begin
        sample <= SIGNED_OUT ?
                  {~sr[DATA_W-1], sr[DATA_W-2:0]} : sr;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: directed checks of adc_spi_reader
// against three parameter sets sharing one clock.
module tb_adc_spi_reader;

  logic        clk;
  logic        rst;
  logic        ready;
  logic [15:0] adc_word;
  logic        en    [3];
  logic        cnv   [3];
  logic        sck   [3];
  logic        sdi   [3];
  logic        valid [3];
  logic        busy  [3];
  logic        ovr   [3];
  logic [15:0] smp   [3];

  int tests = 0;
  int fails = 0;

  int ncnv, ncnvr, cnv2_at, nsck, nboth;
  int nv, novr, ovr_at;
  logic [15:0] s78, s79;
  logic v78, v79, b1, b79;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_spi_reader #(
    .DATA_W(16), .CLK_DIV(2), .CNV_CYCLES(3),
    .CONV_WAIT(10), .SAMPLE_PERIOD(100),
    .SIGNED_OUT(1'b1)
  ) u0 (
    .clk(clk), .rst(rst), .en(en[0]),
    .cnv_adc(cnv[0]), .sck_adc(sck[0]),
    .sdi_adc(sdi[0]), .sample(smp[0]),
    .sample_valid(valid[0]), .sample_ready(ready),
    .busy(busy[0]), .overrun(ovr[0])
  );

  adc_spi_reader #(
    .DATA_W(16), .CLK_DIV(2), .CNV_CYCLES(3),
    .CONV_WAIT(10), .SAMPLE_PERIOD(100),
    .SIGNED_OUT(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .en(en[1]),
    .cnv_adc(cnv[1]), .sck_adc(sck[1]),
    .sdi_adc(sdi[1]), .sample(smp[1]),
    .sample_valid(valid[1]), .sample_ready(ready),
    .busy(busy[1]), .overrun(ovr[1])
  );

  adc_spi_reader #(
    .DATA_W(16), .CLK_DIV(2), .CNV_CYCLES(3),
    .CONV_WAIT(10), .SAMPLE_PERIOD(50),
    .SIGNED_OUT(1'b1)
  ) u2 (
    .clk(clk), .rst(rst), .en(en[2]),
    .cnv_adc(cnv[2]), .sck_adc(sck[2]),
    .sdi_adc(sdi[2]), .sample(smp[2]),
    .sample_valid(valid[2]), .sample_ready(ready),
    .busy(busy[2]), .overrun(ovr[2])
  );

  for (genvar g = 0; g < 3; g++) begin : adc
    logic [15:0] sh = 16'hFFFF;
    always @(posedge cnv[g]) sh = adc_word;
    always @(negedge sck[g]) sh = {sh[14:0], 1'b0};
    assign sdi[g] = sh[15];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // rdy_at: -1 ready always, 0 never, k only in cycle k
  task automatic frame(input int s,
                       input logic [15:0] w,
                       input int rdy_at,
                       input int en_len,
                       input int n);
    logic pc;
    logic ps;
    adc_word = w;
    ready    = (rdy_at == -1);
    en[s]    = 1'b1;
    ncnv = 0; ncnvr = 0; cnv2_at = 0;
    nsck = 0; nboth = 0; nv = 0;
    novr = 0; ovr_at = 0;
    pc = 1'b0;
    ps = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      en[s] = (i < en_len);
      ready = (rdy_at == -1) || (rdy_at == i);
      if (cnv[s]) ncnv++;
      if (cnv[s] && !pc) begin
        ncnvr++;
        if (ncnvr == 2) cnv2_at = i;
      end
      pc = cnv[s];
      if (sck[s] && !ps) nsck++;
      ps = sck[s];
      if (cnv[s] && sck[s]) nboth++;
      if (valid[s]) nv++;
      if (ovr[s]) begin
        novr++;
        if (ovr_at == 0) ovr_at = i;
      end
      if (i == 1) b1 = busy[s];
      if (i == 78) begin
        s78 = smp[s];
        v78 = valid[s];
      end
      if (i == 79) begin
        s79 = smp[s];
        v79 = valid[s];
        b79 = busy[s];
      end
    end
    en[s] = 1'b0;
  endtask

  task automatic fresh(input string tag,
                       input int s,
                       input logic [15:0] w,
                       input logic [15:0] exp);
    frame(s, w, -1, 1, 90);
    chk({tag, "_cnv_cycles"}, ncnv, 3);
    chk({tag, "_sck_rises"}, nsck, 16);
    chk({tag, "_cnv_sck_overlap"}, nboth, 0);
    chk({tag, "_valid_t78"}, v78, 0);
    chk({tag, "_valid_t79"}, v79, 1);
    chk({tag, "_sample"}, s79, exp);
    chk({tag, "_valid_cycles"}, nv, 1);
    chk({tag, "_busy_t1"}, b1, 1);
    chk({tag, "_busy_t79"}, b79, 0);
    chk({tag, "_overrun"}, novr, 0);
  endtask

  initial begin
    rst      = 1'b1;
    ready    = 1'b1;
    adc_word = 16'h0000;
    for (int k = 0; k < 3; k++) en[k] = 1'b1;

    // reset with en and sdi high
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("rst_outputs_u0",
          {cnv[0], sck[0], valid[0], busy[0],
           ovr[0], smp[0]}, 0);
      chk("rst_outputs_u2",
          {cnv[2], sck[2], valid[2], busy[2],
           ovr[2], smp[2]}, 0);
    end
    for (int k = 0; k < 3; k++) en[k] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst",
        {cnv[0], sck[0], valid[0], busy[0],
         ovr[0], smp[0]}, 0);

    // basic frames and sign conversion
    fresh("f8000", 0, 16'h8000, 16'h0000);
    fresh("fFFFF", 0, 16'hFFFF, 16'h7FFF);
    fresh("f0000", 0, 16'h0000, 16'h8000);
    fresh("f1234raw", 1, 16'h1234, 16'h1234);

    // backpressure: overwrite with overrun
    frame(1, 16'h1111, 0, 1, 90);
    chk("bp1_sample", s79, 16'h1111);
    chk("bp1_valid_cycles", nv, 12);
    chk("bp1_overrun", novr, 0);
    frame(1, 16'h2222, 0, 1, 90);
    chk("bp2_old_sample", s78, 16'h1111);
    chk("bp2_old_valid", v78, 1);
    chk("bp2_new_sample", s79, 16'h2222);
    chk("bp2_valid_cycles", nv, 90);
    chk("bp2_overrun_count", novr, 1);
    chk("bp2_overrun_at", ovr_at, 79);
    // ready only in the load cycle
    frame(1, 16'h3333, 78, 1, 90);
    chk("bp3_sample", s79, 16'h3333);
    chk("bp3_valid", v79, 1);
    chk("bp3_valid_cycles", nv, 90);
    chk("bp3_overrun", novr, 0);

    // reset mid-SHIFT, valid held from before
    adc_word = 16'h5A5A;
    en[1]    = 1'b1;
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    repeat (42) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy_before_rst", busy[1], 1);
    chk("mid_valid_before_rst", valid[1], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_sck", sck[1], 0);
    chk("mid_rst_cnv", cnv[1], 0);
    chk("mid_rst_valid", valid[1], 0);
    chk("mid_rst_busy", busy[1], 0);
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (cnv[1] || sck[1] || valid[1] || busy[1]) nv++;
    end
    chk("post_rst_activity", nv, 0);
    fresh("fA5A5raw", 1, 16'hA5A5, 16'hA5A5);

    // period shorter than a frame
    frame(2, 16'h4000, -1, 1000, 230);
    chk("short_cnv_starts", ncnvr, 3);
    chk("short_second_start", cnv2_at, 101);
    chk("short_overrun_count", novr, 2);
    chk("short_overrun_at", ovr_at, 51);
    chk("short_sample", s79, 16'hC000);
    chk("short_valid_cycles", nv, 2);

    // en dropped as CNV ends
    frame(0, 16'h7FFF, -1, 3, 300);
    chk("endrop_cnv_cycles", ncnv, 3);
    chk("endrop_cnv_starts", ncnvr, 1);
    chk("endrop_valid_t79", v79, 1);
    chk("endrop_sample", s79, 16'hFFFF);
    chk("endrop_valid_cycles", nv, 1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
